// File: rtl/data_buffer.sv
// Staging buffers between the bus, the read controller and the systolic array.
// Weight and input FIFOs feed the controller; the output FIFO collects array results.
module data_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [63:0] wr_data,
    input  logic        get_weights,
    input  logic        get_inputs,
    input  logic        get_out,
    input  logic        array_valid,
    input  logic [63:0] array_out,
    input  logic        rd_out,
    input  logic        err_clr,
    output logic [63:0] data,
    output logic        data_ready,
    output logic [7:0]  num_inputs,
    output logic        output_valid,
    output logic        out_done,
    output logic [63:0] rd_data,
    output logic        occupancy_err
);

    localparam int unsigned WbufDepth = 8;
    localparam int unsigned IbufDepth = 32;
    localparam int unsigned ObufDepth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdData
    } rd_state_e;

    // Weight buffer
    logic [63:0] wbuf_mem [WbufDepth];
    logic [2:0]  wbuf_wr_ptr_q, wbuf_rd_ptr_q;
    logic [3:0]  wbuf_cnt_q, wbuf_cnt_d;
    logic        wbuf_push, wbuf_pop;

    // Input buffer
    logic [63:0] ibuf_mem [IbufDepth];
    logic [4:0]  ibuf_wr_ptr_q, ibuf_rd_ptr_q;
    logic [5:0]  ibuf_cnt_q, ibuf_cnt_d;
    logic        ibuf_push, ibuf_pop;

    // Output buffer
    logic [63:0] obuf_mem [ObufDepth];
    logic [4:0]  obuf_wr_ptr_q, obuf_rd_ptr_q;
    logic [5:0]  obuf_cnt_q, obuf_cnt_d;
    logic        obuf_cap, obuf_push, obuf_drop, obuf_pop, obuf_rd_empty;

    // Read controller
    rd_state_e   state_q, state_d;
    logic [63:0] rd_word_q, rd_word_d;
    logic [63:0] data_q, data_d;
    logic        data_ready_q, data_ready_d;
    logic        rd_empty_err;

    // Result bookkeeping
    logic [7:0]  exp_cnt_q, exp_cnt_d;
    logic [7:0]  cap_cnt_q, cap_cnt_d;
    logic        out_done_q, done_hit;

    logic        wr_reject, err_set, err_q, err_d;

    // Write path: occupancy is judged on pre-edge counts, so a same-cycle pop never makes room.
    always_comb begin
        wbuf_push = wr_en && (wr_sel == 2'b00) && (wbuf_cnt_q < 4'(WbufDepth));
        ibuf_push = wr_en && (wr_sel == 2'b01) && (ibuf_cnt_q < 6'(IbufDepth));
        wr_reject = wr_en && !wbuf_push && !ibuf_push;
    end

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (get_weights || get_inputs) state_d = StRdWait;
            StRdWait: state_d = StRdData;
            StRdData: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Read FSM: outputs. An empty source still walks the FSM and returns zero.
    always_comb begin
        wbuf_pop     = 1'b0;
        ibuf_pop     = 1'b0;
        rd_empty_err = 1'b0;
        rd_word_d    = rd_word_q;
        data_d       = data_q;
        data_ready_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (get_weights) begin
                    if (wbuf_cnt_q != 4'd0) begin
                        wbuf_pop  = 1'b1;
                        rd_word_d = wbuf_mem[wbuf_rd_ptr_q];
                    end else begin
                        rd_empty_err = 1'b1;
                        rd_word_d    = '0;
                    end
                end else if (get_inputs) begin
                    if (ibuf_cnt_q != 6'd0) begin
                        ibuf_pop  = 1'b1;
                        rd_word_d = ibuf_mem[ibuf_rd_ptr_q];
                    end else begin
                        rd_empty_err = 1'b1;
                        rd_word_d    = '0;
                    end
                end
            end
            StRdData: begin
                data_d       = rd_word_q;
                data_ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q    <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
        end else begin
            rd_word_q    <= rd_word_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
        end
    end

    // Output buffer capture and bus pop
    always_comb begin
        obuf_cap      = array_valid && get_out;
        obuf_push     = obuf_cap && (obuf_cnt_q < 6'(ObufDepth));
        obuf_drop     = obuf_cap && !obuf_push;
        obuf_pop      = rd_out && (obuf_cnt_q != 6'd0);
        obuf_rd_empty = rd_out && (obuf_cnt_q == 6'd0);
    end

    always_comb begin
        wbuf_cnt_d = wbuf_cnt_q;
        case ({wbuf_push, wbuf_pop})
            2'b10:   wbuf_cnt_d = wbuf_cnt_q + 4'd1;
            2'b01:   wbuf_cnt_d = wbuf_cnt_q - 4'd1;
            default: ;
        endcase
        ibuf_cnt_d = ibuf_cnt_q;
        case ({ibuf_push, ibuf_pop})
            2'b10:   ibuf_cnt_d = ibuf_cnt_q + 6'd1;
            2'b01:   ibuf_cnt_d = ibuf_cnt_q - 6'd1;
            default: ;
        endcase
        obuf_cnt_d = obuf_cnt_q;
        case ({obuf_push, obuf_pop})
            2'b10:   obuf_cnt_d = obuf_cnt_q + 6'd1;
            2'b01:   obuf_cnt_d = obuf_cnt_q - 6'd1;
            default: ;
        endcase
    end

    // Pointers and counts; storage below is left untouched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_wr_ptr_q <= '0;
            wbuf_rd_ptr_q <= '0;
            wbuf_cnt_q    <= '0;
            ibuf_wr_ptr_q <= '0;
            ibuf_rd_ptr_q <= '0;
            ibuf_cnt_q    <= '0;
            obuf_wr_ptr_q <= '0;
            obuf_rd_ptr_q <= '0;
            obuf_cnt_q    <= '0;
        end else begin
            if (wbuf_push) wbuf_wr_ptr_q <= wbuf_wr_ptr_q + 3'd1;
            if (wbuf_pop)  wbuf_rd_ptr_q <= wbuf_rd_ptr_q + 3'd1;
            if (ibuf_push) ibuf_wr_ptr_q <= ibuf_wr_ptr_q + 5'd1;
            if (ibuf_pop)  ibuf_rd_ptr_q <= ibuf_rd_ptr_q + 5'd1;
            if (obuf_push) obuf_wr_ptr_q <= obuf_wr_ptr_q + 5'd1;
            if (obuf_pop)  obuf_rd_ptr_q <= obuf_rd_ptr_q + 5'd1;
            wbuf_cnt_q <= wbuf_cnt_d;
            ibuf_cnt_q <= ibuf_cnt_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wbuf_push) wbuf_mem[wbuf_wr_ptr_q] <= wr_data;
        if (ibuf_push) ibuf_mem[ibuf_wr_ptr_q] <= wr_data;
        if (obuf_push) obuf_mem[obuf_wr_ptr_q] <= array_out;
    end

    // Completion: dropped captures still count, and a match clears both counters.
    always_comb begin
        done_hit  = get_out && (cap_cnt_q == exp_cnt_q) && !out_done_q;
        exp_cnt_d = done_hit ? 8'd0 : exp_cnt_q + {7'd0, ibuf_pop};
        cap_cnt_d = done_hit ? 8'd0 : cap_cnt_q + {7'd0, obuf_cap};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            out_done_q <= 1'b0;
        end else begin
            exp_cnt_q  <= exp_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            out_done_q <= done_hit;
        end
    end

    // Sticky error: a new error in the same cycle wins over err_clr.
    always_comb begin
        err_set = wr_reject || rd_empty_err || obuf_drop || obuf_rd_empty;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        data          = data_q;
        data_ready    = data_ready_q;
        num_inputs    = {2'b00, ibuf_cnt_q};
        output_valid  = (obuf_cnt_q != 6'd0);
        out_done      = out_done_q;
        rd_data       = (obuf_cnt_q != 6'd0) ? obuf_mem[obuf_rd_ptr_q] : '0;
        occupancy_err = err_q;
    end

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: expected controller words and completion pulses are queued
// by the stimulus and consumed by a negedge monitor; occupancy/flag checks are inline.
module tb_data_buffer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [63:0] wr_data;
    logic        get_weights;
    logic        get_inputs;
    logic        get_out;
    logic        array_valid;
    logic [63:0] array_out;
    logic        rd_out;
    logic        err_clr;
    logic [63:0] data;
    logic        data_ready;
    logic [7:0]  num_inputs;
    logic        output_valid;
    logic        out_done;
    logic [63:0] rd_data;
    logic        occupancy_err;

    data_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .get_weights   (get_weights),
        .get_inputs    (get_inputs),
        .get_out       (get_out),
        .array_valid   (array_valid),
        .array_out     (array_out),
        .rd_out        (rd_out),
        .err_clr       (err_clr),
        .data          (data),
        .data_ready    (data_ready),
        .num_inputs    (num_inputs),
        .output_valid  (output_valid),
        .out_done      (out_done),
        .rd_data       (rd_data),
        .occupancy_err (occupancy_err)
    );

    typedef struct {
        logic [63:0] word;
        int          due;
    } exp_t;

    exp_t rd_q[$];
    int   od_q[$];
    exp_t mon_e;
    int   mon_due;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-chosen word patterns: a tag in the upper half, the index in the lower half.
    function automatic logic [63:0] wv(input int r, input int i);
        return {32'hA5A5_0000 + 32'(r), 32'(i)};
    endfunction
    function automatic logic [63:0] iv(input int i);
        return {32'h1B0F_0000, 32'(i)};
    endfunction
    function automatic logic [63:0] jv(input int i);
        return {32'hCAFE_0000, 32'(i)};
    endfunction
    function automatic logic [63:0] av(input int i);
        return {32'h0A77_0000, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] sel, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // One controller request; the reply is expected in the cycle after the third edge.
    task automatic request(input bit weights, input logic [63:0] word);
        exp_t e;
        e.word = word;
        e.due  = cyc + 3;
        rd_q.push_back(e);
        get_weights = weights;
        get_inputs  = !weights;
        tick();
        get_weights = 1'b0;
        get_inputs  = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 64'(occupancy_err), 64'd0);
    endtask

    // Monitor: every data_ready / out_done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_data_ready", 64'd1, 64'd0);
            end else begin
                mon_e = rd_q.pop_front();
                chk("read_word", data, mon_e.word);
                chk("read_latency_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
        if (out_done === 1'b1) begin
            if (od_q.size() == 0) begin
                chk("unexpected_out_done", 64'd1, 64'd0);
            end else begin
                mon_due = od_q.pop_front();
                chk("out_done_cycle", 64'(cyc), 64'(mon_due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 2'b00; wr_data = '0;
        get_weights = 1'b0; get_inputs = 1'b0; get_out = 1'b0;
        array_valid = 1'b0; array_out = '0; rd_out = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_data", data, 64'd0);
        chk("reset_data_ready", 64'(data_ready), 64'd0);
        chk("reset_num_inputs", 64'(num_inputs), 64'd0);
        chk("reset_output_valid", 64'(output_valid), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_err", 64'(occupancy_err), 64'd0);

        // Eight weights in, eight requests three cycles apart, FIFO order out.
        for (int i = 0; i < 8; i++) write(2'b00, wv(1, i));
        for (int i = 0; i < 8; i++) request(1'b1, wv(1, i));
        repeat (3) tick();
        chk("data_holds_last", data, wv(1, 7));
        chk("weights_no_err", 64'(occupancy_err), 64'd0);

        // Fill WBUF, ninth write is dropped and flags an error.
        for (int i = 0; i < 8; i++) write(2'b00, wv(2, i));
        chk("wbuf_full_no_err_yet", 64'(occupancy_err), 64'd0);
        write(2'b00, wv(2, 99));
        chk("wbuf_overflow_err", 64'(occupancy_err), 64'd1);
        clear_err();
        // Invalid target together with err_clr: the new error wins.
        err_clr = 1'b1;
        write(2'b10, 64'h0);
        err_clr = 1'b0;
        chk("set_beats_clear", 64'(occupancy_err), 64'd1);
        clear_err();

        // Input request on an empty IBUF still completes with zero.
        request(1'b0, 64'd0);
        chk("empty_read_err", 64'(occupancy_err), 64'd1);
        clear_err();

        // Results arriving without get_out are discarded.
        array_valid = 1'b1;
        array_out   = 64'hDEAD;
        tick();
        array_valid = 1'b0;
        chk("no_capture_without_get_out", 64'(output_valid), 64'd0);
        chk("no_capture_no_err", 64'(occupancy_err), 64'd0);

        // Fill IBUF, pop four, then collect four results.
        for (int i = 0; i < 32; i++) write(2'b01, iv(i));
        chk("ibuf_full_count", 64'(num_inputs), 64'd32);
        write(2'b01, iv(99));
        chk("ibuf_overflow_err", 64'(occupancy_err), 64'd1);
        clear_err();
        for (int i = 0; i < 4; i++) request(1'b0, iv(i));
        chk("ibuf_after_4_pops", 64'(num_inputs), 64'd28);
        od_q.push_back(cyc + 5);
        get_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            array_valid = 1'b1;
            array_out   = av(i);
            tick();
        end
        array_valid = 1'b0;
        tick();
        get_out = 1'b0;
        chk("obuf_valid", 64'(output_valid), 64'd1);
        chk("obuf_head_fwft", rd_data, av(0));
        for (int i = 0; i < 4; i++) begin
            rd_out = 1'b1;
            chk("obuf_pop_order", rd_data, av(i));
            tick();
        end
        rd_out = 1'b0;
        chk("obuf_drained_valid", 64'(output_valid), 64'd0);
        chk("obuf_drained_rd_data", rd_data, 64'd0);
        chk("obuf_drain_no_err", 64'(occupancy_err), 64'd0);
        rd_out = 1'b1;
        tick();
        rd_out = 1'b0;
        chk("obuf_empty_pop_err", 64'(occupancy_err), 64'd1);
        clear_err();

        // IBUF wrap: 20 popped in total, 20 more written, drain in order.
        for (int i = 4; i < 20; i++) request(1'b0, iv(i));
        for (int i = 0; i < 20; i++) write(2'b01, jv(i));
        chk("ibuf_wrap_count", 64'(num_inputs), 64'd32);
        for (int i = 20; i < 32; i++) request(1'b0, iv(i));
        for (int i = 0; i < 20; i++) request(1'b0, jv(i));
        chk("ibuf_wrap_empty", 64'(num_inputs), 64'd0);
        chk("ibuf_wrap_no_err", 64'(occupancy_err), 64'd0);

        // Reset while the read sits in RD_WAIT: no reply, everything back to reset values.
        write(2'b01, iv(200));
        write(2'b01, iv(201));
        write(2'b11, 64'h0);
        chk("pre_reset_err", 64'(occupancy_err), 64'd1);
        get_weights = 1'b1;
        tick();
        get_weights = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midread_rst_data", data, 64'd0);
        chk("midread_rst_data_ready", 64'(data_ready), 64'd0);
        chk("midread_rst_num_inputs", 64'(num_inputs), 64'd0);
        chk("midread_rst_output_valid", 64'(output_valid), 64'd0);
        chk("midread_rst_out_done", 64'(out_done), 64'd0);
        chk("midread_rst_err", 64'(occupancy_err), 64'd0);
        repeat (4) tick();
        // Stale contents are treated as empty.
        request(1'b1, 64'd0);
        chk("post_reset_wbuf_empty_err", 64'(occupancy_err), 64'd1);
        clear_err();
        request(1'b0, 64'd0);
        chk("post_reset_ibuf_empty_err", 64'(occupancy_err), 64'd1);

        repeat (5) tick();
        chk("read_replies_outstanding", 64'(rd_q.size()), 64'd0);
        chk("out_done_outstanding", 64'(od_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
